// File: rtl/hba_pkg.sv
// Shared HBA bus constants plus arbiter state encoding and counter widths.
package hba_pkg;

    // HBA bus widths shared across the peripheral slice
    localparam int unsigned DBUS_WIDTH        = 8;
    localparam int unsigned PERIPH_ADDR_WIDTH = 4;
    localparam int unsigned REG_ADDR_WIDTH    = 8;

    // Arbiter widths: grant id is always 3 bits (up to 8 masters)
    localparam int unsigned GRANT_ID_WIDTH    = 3;
    localparam int unsigned HOLD_CNT_WIDTH    = 16;
    localparam int unsigned STATE_WIDTH       = 2;

    // Arbiter FSM encoding
    localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_WIDTH-1:0] ST_GRANT = 2'd1;
    localparam logic [STATE_WIDTH-1:0] ST_TURN  = 2'd2;

endpackage

// File: rtl/hba_rr_select.sv
// Combinational round-robin search: first unmasked requester after last_owner.
module hba_rr_select
    import hba_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]    req,
    input  logic [NUM_MASTERS-1:0]    mask,
    input  logic [GRANT_ID_WIDTH-1:0] last_owner,
    output logic [GRANT_ID_WIDTH-1:0] winner,
    output logic                      valid
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] elig;

    assign elig = req & ~mask;

    // Walk offsets from farthest to nearest so the nearest eligible index wins
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
            idx = (32'(last_owner) + k) % NUM_MASTERS;
            if (elig[IDX_W'(idx)]) begin
                winner = GRANT_ID_WIDTH'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hba_arbiter.sv
// Round-robin HBA bus arbiter with turnaround cycle, hold timeout and lockout.
module hba_arbiter
    import hba_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned HOLD_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    hba_mreq,
    output logic [NUM_MASTERS-1:0]    hba_mgrant,
    output logic [GRANT_ID_WIDTH-1:0] hba_grant_id,
    output logic                      hba_busy,
    output logic                      hba_timeout
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST = HOLD_CNT_WIDTH'(HOLD_TIMEOUT - 1);

    logic [STATE_WIDTH-1:0]    state, state_nxt;
    logic [GRANT_ID_WIDTH-1:0] last_owner, last_owner_nxt;
    logic [HOLD_CNT_WIDTH-1:0] hold_cnt, hold_cnt_nxt;
    logic [NUM_MASTERS-1:0]    lockout, lockout_nxt, lock_set;
    logic [NUM_MASTERS-1:0]    mgrant_nxt;
    logic [GRANT_ID_WIDTH-1:0] grant_id_nxt;
    logic                      busy_nxt;
    logic                      timeout_nxt;

    logic [GRANT_ID_WIDTH-1:0] rr_winner;
    logic                      rr_valid;
    logic [IDX_W-1:0]          owner_idx;

    assign owner_idx = last_owner[IDX_W-1:0];

    hba_rr_select #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_select (
        .req        (hba_mreq),
        .mask       (lockout),
        .last_owner (last_owner),
        .winner     (rr_winner),
        .valid      (rr_valid)
    );

    // State and registered outputs; reset drops any grant immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_owner   <= GRANT_ID_WIDTH'(NUM_MASTERS - 1);
            hold_cnt     <= '0;
            lockout      <= '0;
            hba_mgrant   <= '0;
            hba_grant_id <= '0;
            hba_busy     <= 1'b0;
            hba_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_owner   <= last_owner_nxt;
            hold_cnt     <= hold_cnt_nxt;
            lockout      <= lockout_nxt;
            hba_mgrant   <= mgrant_nxt;
            hba_grant_id <= grant_id_nxt;
            hba_busy     <= busy_nxt;
            hba_timeout  <= timeout_nxt;
        end
    end

    // Next-state and next-output decode; requests are only evaluated in IDLE
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = hold_cnt;
        mgrant_nxt     = hba_mgrant;
        grant_id_nxt   = hba_grant_id;
        busy_nxt       = hba_busy;
        timeout_nxt    = hba_timeout;
        lock_set       = '0;

        case (state)
            ST_IDLE: begin
                if (rr_valid) begin
                    state_nxt      = ST_GRANT;
                    last_owner_nxt = rr_winner;
                    hold_cnt_nxt   = '0;
                    mgrant_nxt     = NUM_MASTERS'(1) << rr_winner;
                    grant_id_nxt   = rr_winner;
                    busy_nxt       = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!hba_mreq[owner_idx]) begin
                    state_nxt    = ST_TURN;
                    mgrant_nxt   = '0;
                    grant_id_nxt = '0;
                    busy_nxt     = 1'b0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt           = ST_TURN;
                    mgrant_nxt          = '0;
                    grant_id_nxt        = '0;
                    busy_nxt            = 1'b0;
                    timeout_nxt         = 1'b1;
                    lock_set[owner_idx] = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_CNT_WIDTH'(1);
                end
            end
            ST_TURN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt    = ST_IDLE;
                mgrant_nxt   = '0;
                grant_id_nxt = '0;
                busy_nxt     = 1'b0;
            end
        endcase

        // A lockout bit survives only while its request stays high
        lockout_nxt = (lockout & hba_mreq) | lock_set;
    end

endmodule

// File: tb/tb_hba_arbiter.sv
// Directed self-checking bench for hba_arbiter (4 masters, hold timeout 8).
module tb_hba_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] hba_mreq;
    logic [3:0] hba_mgrant;
    logic [2:0] hba_grant_id;
    logic       hba_busy;
    logic       hba_timeout;

    int tests_run;
    int tests_failed;

    logic [8:0] obs;
    logic [8:0] exp;

    hba_arbiter #(
        .NUM_MASTERS  (4),
        .HOLD_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hba_mreq     (hba_mreq),
        .hba_mgrant   (hba_mgrant),
        .hba_grant_id (hba_grant_id),
        .hba_busy     (hba_busy),
        .hba_timeout  (hba_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle {grant, id, busy, timeout} from a one-hot grant
    function automatic logic [8:0] pack(input logic [3:0] g, input logic t);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) id = 3'(i);
        end
        return {g, id, |g, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        hba_mreq = 4'b0000;
        tick();
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        hba_mreq = 4'b0000;
        tick();
        tick();
        obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
        exp = pack(4'b0000, 1'b0);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_state: got %b want %b", obs, exp);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
            exp = pack(4'b0000, 1'b0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL idle_no_req cycle %0d: got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_single();
        for (int r = 0; r < 2; r++) begin
            hba_mreq = 4'b0100;
            tick();
            obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
            exp = pack(4'b0100, 1'b0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL single_grant round %0d: got %b want %b", r, obs, exp);
            end
            for (int i = 0; i < 3; i++) begin
                tick();
                obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL single_hold round %0d cycle %0d: got %b want %b", r, i, obs, exp);
                end
            end
            hba_mreq = 4'b0000;
            for (int i = 0; i < 2; i++) begin
                tick();
                obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
                exp = pack(4'b0000, 1'b0);
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL single_gap round %0d cycle %0d: got %b want %b", r, i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        logic [1:0] m;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        hba_mreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            m = order[i];
            tick();
            obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
            exp = pack(4'b0001 << m, 1'b0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL rr_grant step %0d: got %b want %b", i, obs, exp);
            end
            for (int h = 0; h < 2; h++) begin
                tick();
                obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL rr_hold step %0d cycle %0d: got %b want %b", i, h, obs, exp);
                end
            end
            hba_mreq[m] = 1'b0;
            tick();
            hba_mreq[m] = 1'b1;
            obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
            exp = pack(4'b0000, 1'b0);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL rr_gap_turn step %0d: got %b want %b", i, obs, exp);
            end
            tick();
            obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL rr_gap_idle step %0d: got %b want %b", i, obs, exp);
            end
        end
        hba_mreq = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        hba_mreq = 4'b1010;
        tick();
        exp = pack(4'b0010, 1'b0);
        for (int i = 0; i < 8; i++) begin
            obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL to_hold cycle %0d: got %b want %b", i, obs, exp);
            end
            if (i < 7) tick();
        end
        tick();
        obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
        exp = pack(4'b0000, 1'b1);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL to_release: got %b want %b", obs, exp);
        end
        tick();
        obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL to_gap: got %b want %b", obs, exp);
        end
        tick();
        obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
        exp = pack(4'b1000, 1'b1);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL to_grant3: got %b want %b", obs, exp);
        end
        hba_mreq = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
            exp = pack(4'b0000, 1'b1);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL to_lockout cycle %0d: got %b want %b", i, obs, exp);
            end
        end
        hba_mreq = 4'b0000;
        tick();
        hba_mreq = 4'b0010;
        tick();
        obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
        exp = pack(4'b0010, 1'b1);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL to_regrant1: got %b want %b", obs, exp);
        end
        hba_mreq = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        hba_mreq = 4'b0100;
        tick();
        obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
        exp = pack(4'b0100, 1'b1);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL mid_grant: got %b want %b", obs, exp);
        end
        reset = 1'b1;
        tick();
        obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
        exp = pack(4'b0000, 1'b0);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL mid_reset: got %b want %b", obs, exp);
        end
        reset    = 1'b0;
        hba_mreq = 4'b0101;
        tick();
        obs = {hba_mgrant, hba_grant_id, hba_busy, hba_timeout};
        exp = pack(4'b0001, 1'b0);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL post_reset_grant: got %b want %b", obs, exp);
        end
        hba_mreq = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        hba_mreq     = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hba_arbiter.md
HBA_ARBITER -- requirements
Module: hba_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of HBA bus masters sharing one slave bus (legal 2..8).
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 1024, max cycles one master may hold the bus (legal 2..65535).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hba_mreq  input  NUM_MASTERS  per-master bus request, level, held for whole transaction.
REQ-006 SHALL have port hba_mgrant  output  NUM_MASTERS  per-master grant, registered, one-hot or zero.
REQ-007 SHALL have port hba_grant_id  output  3  binary index of granted master; 0 when no grant.
REQ-008 SHALL have port hba_busy  output  1  high while any grant asserted.
REQ-009 SHALL have port hba_timeout  output  1  sticky flag, set on forced release, cleared only by reset.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT, TURN.
REQ-011 SHALL, in IDLE with any hba_mreq bit high, select a winner by round-robin and enter GRANT; hba_mgrant asserts the cycle after the request is first sampled (1-cycle latency).
REQ-012 SHALL search round-robin starting at index (last_owner+1) mod NUM_MASTERS, ascending, wrapping.
REQ-013 SHALL update last_owner to the winner when entering GRANT.
REQ-014 SHALL hold hba_mgrant constant in GRANT while hba_mreq[owner] stays high; other requests ignored.
REQ-015 SHALL, when hba_mreq[owner] is sampled low in GRANT, deassert hba_mgrant next cycle and enter TURN.
REQ-016 SHALL spend exactly one cycle in TURN with hba_mgrant all zero (bus turnaround), then enter IDLE.
REQ-017 SHALL, so that the minimum gap between two grants is 2 zero cycles, evaluate requests only in IDLE, never in TURN.
REQ-018 SHALL count cycles in GRANT with a hold counter reset on GRANT entry; when count reaches HOLD_TIMEOUT, force release (enter TURN), set hba_timeout.
REQ-019 SHALL, after forced release, not re-grant the timed-out master until its hba_mreq has been sampled low at least once (per-master lockout bit, cleared on req low).
REQ-020 SHALL, with all requests low or locked out in IDLE, remain in IDLE with no grant.
REQ-021 SHALL, with a single persistent requester, re-grant that same master after each TURN+IDLE gap.
REQ-022 SHALL derive hba_busy and hba_grant_id from registered state (no combinational path from hba_mreq to outputs).
REQ-023 SHALL ignore hba_mreq bits beyond NUM_MASTERS-1 (none exist; width rule: grant_id zero-extended to 3 bits).

Reset
REQ-024 SHALL, on reset high at a clock edge, force state IDLE, hba_mgrant=0, hba_grant_id=0, hba_busy=0, hba_timeout=0, hold counter=0, lockout bits=0.
REQ-025 SHALL reset last_owner to NUM_MASTERS-1 so master 0 has first priority.
REQ-026 SHALL, on reset asserted mid-GRANT, drop grant at that edge with no TURN cycle.
REQ-027 SHALL take first arbitration decision in the first IDLE cycle after reset deasserts.

Structure
REQ-028 SHALL take state encoding and HOLD counter width constants from shared package hba_pkg (alongside HBA bus width constants DBUS_WIDTH=8, PERIPH_ADDR_WIDTH=4, REG_ADDR_WIDTH=8).
REQ-029 SHALL place round-robin search in one combinational sub-module hba_rr_select (inputs req, mask, last_owner; outputs winner index, valid).
REQ-030 SHALL keep all registers in hba_arbiter; no latches, no clock gating.

Verification
REQ-031 Reset release, hba_mreq=4'b0000 for 10 cycles -> hba_mgrant=0, hba_busy=0, hba_grant_id=0 throughout.
REQ-032 hba_mreq=4'b1111 held, each owner drops req 3 cycles after grant then re-raises -> grant order 0,1,2,3,0; each handoff shows 2 zero-grant cycles.
REQ-033 hba_mreq=4'b0100 raised at cycle N -> hba_mgrant=4'b0100, hba_grant_id=2 at cycle N+1; drop at M -> grant 0 at M+1, next IDLE at M+2.
REQ-034 HOLD_TIMEOUT=8, master 1 holds req indefinitely, master 3 requests -> grant to 1 released after 8 cycles, hba_timeout=1, master 3 granted; master 1 not re-granted until its req toggles low.
REQ-035 Reset asserted during GRANT of master 2 -> hba_mgrant=0 next edge, hba_timeout=0; after release with hba_mreq=4'b0101 master 0 granted first.
